skinny_sbox8_dom1_seq: RTL and testbench
========================================

SKINNY_SBOX8_DOM1_SEQ -- requirements
Module: skinny_sbox8_dom1_seq

Interface
REQ-001 SHALL have parameter SBOX_LAT, default 4, meaning the number of clock edges the attached DOM1 sbox8 needs from stable input to valid output.
REQ-002 SHALL have parameter NBYTES, default 16, meaning the number of state bytes substituted per run.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request one SubCells pass; sampled only in IDLE.
REQ-006 st0_i, st1_i  input  8*NBYTES each  share 0 / share 1 of the masked state, loaded on accepted start.
REQ-007 st0_o, st1_o  output  8*NBYTES each  share 0 / share 1 of the working state register.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when a pass completes.
REQ-010 rnd_i  input  8  fresh refreshing mask byte.
REQ-011 rnd_valid  input  1  rnd_i holds a fresh byte.
REQ-012 rnd_ready  output  1  controller consumes rnd_i this cycle.
REQ-013 sbox_si0, sbox_si1  output  8 each  registered share inputs to the sbox.
REQ-014 sbox_r  output  8  registered refreshing mask to the sbox.
REQ-015 sbox_bo0, sbox_bo1  input  8 each  sbox output shares.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, HOLD, CAPT, DONE; byte index idx (0..NBYTES-1) and hold counter cnt (0..SBOX_LAT-1).
REQ-017 IDLE: on start=1, SHALL load st0_i/st1_i into the working state, clear idx, go to FETCH; start while busy SHALL be ignored.
REQ-018 FETCH: rnd_ready SHALL equal 1; on rnd_valid=1, SHALL load sbox_r<=rnd_i, sbox_si0<=state0 byte idx, sbox_si1<=state1 byte idx (byte idx = bits [8*idx+7:8*idx]), clear cnt, go to HOLD; on rnd_valid=0 SHALL stay, all sbox_* registers unchanged.
REQ-019 rnd_ready SHALL be 0 in every state but FETCH; exactly one rnd byte SHALL be consumed per substituted byte; no byte reused.
REQ-020 HOLD: cnt SHALL increment each cycle; on the edge where cnt==SBOX_LAT-1 SHALL go to CAPT.
REQ-021 sbox_si0, sbox_si1, sbox_r SHALL remain unchanged from the FETCH load edge through the end of CAPT (at least SBOX_LAT+1 cycles).
REQ-022 CAPT: SHALL write sbox_bo0/sbox_bo1 into byte idx of state0/state1; if idx==NBYTES-1 go to DONE, else idx<=idx+1, go to FETCH.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; st0_o/st1_o SHALL hold the substituted shares until the next accepted start.
REQ-024 Unstalled pass latency SHALL be NBYTES*(SBOX_LAT+2)+1 cycles from start edge to done pulse (97 at defaults).
REQ-025 The two shares SHALL never be combined (XORed) anywhere inside the block; each share path uses only its own share and sbox_r.
REQ-026 Bytes other than idx SHALL not change during a pass.

Reset
REQ-027 On rst=1 at a clock edge, SHALL go to IDLE and clear working state, sbox_si0, sbox_si1, sbox_r, idx, cnt to 0; busy=0, done=0, rnd_ready=0.
REQ-028 rst SHALL take priority over start and over any in-progress pass; a pass aborted by rst SHALL not produce done.

Verification
REQ-029 Shares of all-zero state (st0_i=random R, st1_i=R), rnd always valid -> done at cycle 97; every byte of st0_o^st1_o = 0x65.
REQ-030 Unmasked state 0xFF..FF with random share split -> every byte of st0_o^st1_o = 0xFF; each byte of st0_o differs from its input share for at least one byte (remasking observed).
REQ-031 rnd_valid held low 10 cycles in FETCH of byte 5 -> rnd_ready high throughout, sbox_* registers stable, done delayed by exactly 10 cycles, result unchanged.
REQ-032 rst asserted in HOLD of byte 7 -> next cycle busy=0, st0_o=st1_o=0, no done; a following start runs a full correct pass.
REQ-033 start pulsed while busy -> ignored; working state not reloaded; single done.
REQ-034 Random unmasked states (>=1000) versus SKINNY-128 S8 table -> st0_o^st1_o equals S8 applied bytewise; sbox_* inputs checked stable for SBOX_LAT+1 cycles per byte.

Source files
------------

// File: rtl/skinny_sbox8_dom1_seq_if.sv
// Command/state bus and refreshing-mask handshake between a client and the
// sequential DOM1 SubCells controller.
interface skinny_sbox8_dom1_seq_if #(
  parameter int NBYTES = 16
);
  logic                start;
  logic [8*NBYTES-1:0] st0_i, st1_i;
  logic [8*NBYTES-1:0] st0_o, st1_o;
  logic                busy, done;
  logic [7:0]          rnd_i;
  logic                rnd_valid, rnd_ready;

  modport master (
    output start, st0_i, st1_i, rnd_i, rnd_valid,
    input  st0_o, st1_o, busy, done, rnd_ready
  );
  modport slave (
    input  start, st0_i, st1_i, rnd_i, rnd_valid,
    output st0_o, st1_o, busy, done, rnd_ready
  );
endinterface

// File: rtl/skinny_sbox8_dom1_seq.sv
// Byte-serial SubCells controller driving an external first-order DOM sbox8:
// one byte per FETCH/HOLD/CAPT round, one fresh mask byte consumed per byte.
module skinny_sbox8_dom1_seq #(
  parameter int SBOX_LAT = 4,
  parameter int NBYTES   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  skinny_sbox8_dom1_seq_if.slave bus,
  output logic [7:0]             sbox_si0,
  output logic [7:0]             sbox_si1,
  output logic [7:0]             sbox_r,
  input  logic [7:0]             sbox_bo0,
  input  logic [7:0]             sbox_bo1
);
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(SBOX_LAT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, HOLD, CAPT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx;
  logic [CW-1:0]          cnt;
  logic [NBYTES-1:0][7:0] sh0, sh1;
  logic                   load, fetch, capt, rnd_rdy;

  assign load  = (state_q == IDLE) && bus.start;
  assign fetch = (state_q == FETCH) && bus.rnd_valid;
  assign capt  = (state_q == CAPT);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rnd_rdy = 1'b0;
    case (state_q)
      IDLE:  if (bus.start) state_d = FETCH;
      FETCH: begin
        rnd_rdy = 1'b1;
        if (bus.rnd_valid) state_d = HOLD;
      end
      HOLD:  if (cnt == LAST_CNT) state_d = CAPT;
      CAPT:  state_d = (idx == LAST_IDX) ? DONE : FETCH;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.rnd_ready = rnd_rdy;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.st0_o     = sh0;
  assign bus.st1_o     = sh1;

  // Sbox operands are only written on the FETCH handshake, so they stay put
  // for the whole HOLD/CAPT window the masked sbox relies on.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      cnt      <= '0;
      sbox_si0 <= '0;
      sbox_si1 <= '0;
      sbox_r   <= '0;
    end else begin
      if (load) idx <= '0;
      if (fetch) begin
        sbox_si0 <= sh0[idx];
        sbox_si1 <= sh1[idx];
        sbox_r   <= bus.rnd_i;
        cnt      <= '0;
      end
      if (state_q == HOLD) cnt <= cnt + 1'b1;
      if (capt && idx != LAST_IDX) idx <= idx + 1'b1;
    end
  end

  // Per-byte share lanes; each share lane sees only its own share input.
  for (genvar b = 0; b < NBYTES; b++) begin : g_lane
    logic [7:0] b0_q, b1_q;
    logic       hit;
    assign hit = capt && (idx == IW'(b));
    always_ff @(posedge clk) begin
      if (rst) begin
        b0_q <= '0;
        b1_q <= '0;
      end else if (load) begin
        b0_q <= bus.st0_i[8*b +: 8];
        b1_q <= bus.st1_i[8*b +: 8];
      end else if (hit) begin
        b0_q <= sbox_bo0;
        b1_q <= sbox_bo1;
      end
    end
    assign sh0[b] = b0_q;
    assign sh1[b] = b1_q;
  end
endmodule

// File: tb/tb_skinny_sbox8_dom1_seq.sv
// Scoreboard bench: behavioural pipelined masked sbox, mask-byte source with
// stall injection, driver pushing expected pass results, monitor on done.
module tb_skinny_sbox8_dom1_seq;
  localparam int L  = 4;
  localparam int NB = 16;
  localparam int W  = 8 * NB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sbox_si0, sbox_si1, sbox_r, sbox_bo0, sbox_bo1;
  int         tests = 0, fails = 0, cyc = 0;

  skinny_sbox8_dom1_seq_if #(.NBYTES(NB)) bus();

  skinny_sbox8_dom1_seq #(.SBOX_LAT(L), .NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .sbox_si0(sbox_si0), .sbox_si1(sbox_si1), .sbox_r(sbox_r),
    .sbox_bo0(sbox_bo0), .sbox_bo1(sbox_bo1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] s8(input logic [7:0] a);
    logic [7:0] x;
    x = a;
    for (int r = 0; r < 4; r++) begin
      x[4] = x[4] ^ ~(x[7] | x[6]);
      x[0] = x[0] ^ ~(x[3] | x[2]);
      if (r < 3) x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
      else       x = {x[7:3], x[1], x[2], x[0]};
    end
    return x;
  endfunction

  // Masked sbox stand-in: L-stage pipeline, output valid L edges after input.
  logic [7:0] p0 [L];
  logic [7:0] p1 [L];
  always @(posedge clk) begin
    p0[0] <= sbox_si0 ^ sbox_r;
    p1[0] <= s8(sbox_si0 ^ sbox_si1) ^ sbox_si0 ^ sbox_r;
    for (int i = 1; i < L; i++) begin
      p0[i] <= p0[i-1];
      p1[i] <= p1[i-1];
    end
  end
  assign sbox_bo0 = p0[L-1];
  assign sbox_bo1 = p1[L-1];

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] s0;
    int           lat;
    int           cs;
    bit           rm;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string n, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  // Mask source, operand-load and operand-stability checks.
  logic [W-1:0] cur_s0, cur_s1;
  int  hs_cnt = 0, stall_at = 5, stall_left = 0, trk = 0;
  bit  pend = 0, prev_stall = 0, stab_bad = 0;
  logic [7:0] rec0, rec1, recr;
  initial begin
    bus.rnd_valid = 1'b1;
    bus.rnd_i     = 8'($urandom_range(1, 255));
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        trk = 0; pend = 0; prev_stall = 0;
      end else begin
        if (prev_stall) begin
          tests++;
          if (!bus.rnd_ready || sbox_si0 !== rec0 || sbox_si1 !== rec1 || sbox_r !== recr) begin
            fails++;
            $display("FAIL stall_stable ready=%b si0=%h si1=%h r=%h exp %h %h %h",
                     bus.rnd_ready, sbox_si0, sbox_si1, sbox_r, rec0, rec1, recr);
          end
        end
        if (pend) begin
          rec0 = sbox_si0; rec1 = sbox_si1; recr = sbox_r;
          tests++;
          if (recr !== bus.rnd_i || rec0 !== cur_s0[8*hs_cnt +: 8] || rec1 !== cur_s1[8*hs_cnt +: 8]) begin
            fails++;
            $display("FAIL sbox_load byte=%0d got %h %h %h exp %h %h %h", hs_cnt, rec0, rec1, recr,
                     cur_s0[8*hs_cnt +: 8], cur_s1[8*hs_cnt +: 8], bus.rnd_i);
          end
          hs_cnt++;
          trk = L + 1; stab_bad = 0;
          bus.rnd_i = 8'($urandom_range(1, 255));
        end else if (trk > 0) begin
          if (sbox_si0 !== rec0 || sbox_si1 !== rec1 || sbox_r !== recr) stab_bad = 1;
          trk--;
          if (trk == 0) begin
            tests++;
            if (stab_bad) begin
              fails++;
              $display("FAIL sbox_hold byte=%0d now %h %h %h exp %h %h %h", hs_cnt - 1,
                       sbox_si0, sbox_si1, sbox_r, rec0, rec1, recr);
            end
          end
        end
      end
      if (bus.start && !bus.busy && !rst) hs_cnt = 0;
      prev_stall = 0;
      if (stall_left > 0 && hs_cnt == stall_at && bus.rnd_ready) begin
        bus.rnd_valid = 1'b0;
        stall_left--;
        prev_stall = 1;
      end else begin
        bus.rnd_valid = 1'b1;
      end
      pend = bus.rnd_valid && bus.rnd_ready && !rst;
    end
  end

  // Monitor: pops one expectation per done pulse.
  bit prev_done = 0;
  initial begin
    forever begin
      @(negedge clk); #1;
      if (!rst && bus.done) begin
        tests++;
        if (prev_done) begin
          fails++;
          $display("FAIL done_width got=2+ cycles exp=1");
        end else if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done got=1 exp=0");
        end else begin
          exp_t e;
          e = q.pop_front();
          tests--;
          chk("result_xor", bus.st0_o ^ bus.st1_o, e.x);
          chk("latency", W'(cyc - e.cs + 1), W'(e.lat));
          if (e.rm) begin
            tests++;
            if (bus.st0_o === e.s0) begin
              fails++;
              $display("FAIL remask got=%h exp!=%h", bus.st0_o, e.s0);
            end
          end
        end
      end
      prev_done = bus.done && !rst;
    end
  end

  task automatic run_pass(input logic [W-1:0] s0, s1, x, input int stall, input bit rm, input bit extra);
    exp_t e;
    int i;
    @(negedge clk);
    cur_s0 = s0; cur_s1 = s1; stall_left = stall;
    bus.start = 1'b1; bus.st0_i = s0; bus.st1_i = s1;
    e.x = x; e.s0 = s0; e.lat = NB * (L + 2) + 1 + stall; e.cs = cyc + 1; e.rm = rm;
    q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0; bus.st0_i = ~s0; bus.st1_i = s1 ^ {NB{8'h3c}};
    if (extra) begin
      repeat (20) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    for (i = 0; i < 2000 && bus.busy; i++) @(negedge clk);
    chk("pass_timeout", W'(bus.busy), '0);
    repeat (3) @(negedge clk);
    chk("done_missing", W'(q.size()), '0);
    q.delete();
    chk("result_hold", bus.st0_o ^ bus.st1_o, x);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r, s1, x;
    int i;
    bus.start = 1'b0; bus.st0_i = '0; bus.st1_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.done), '0);
    chk("rst_ready", W'(bus.rnd_ready), '0);
    chk("rst_st0", bus.st0_o, '0);
    chk("rst_st1", bus.st1_o, '0);
    chk("rst_sbox", W'({sbox_si0, sbox_si1, sbox_r}), '0);
    chk("s8_zero", W'(s8(8'h00)), W'(8'h65));
    chk("s8_ones", W'(s8(8'hff)), W'(8'hff));
    rst = 1'b0;

    r = {$urandom, $urandom, $urandom, $urandom};
    run_pass(r, r, {NB{8'h65}}, 0, 1'b0, 1'b0);

    r = {$urandom, $urandom, $urandom, $urandom};
    run_pass(r, r ^ {NB{8'hff}}, {NB{8'hff}}, 0, 1'b1, 1'b0);
    run_pass(r, r ^ {NB{8'hff}}, {NB{8'hff}}, 10, 1'b1, 1'b0);

    // Abort in HOLD of byte 7; no expectation is queued, so any done fails.
    r = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    cur_s0 = r; cur_s1 = ~r;
    bus.start = 1'b1; bus.st0_i = r; bus.st1_i = ~r;
    @(negedge clk);
    bus.start = 1'b0;
    for (i = 0; i < 300 && hs_cnt < 8; i++) @(negedge clk);
    chk("abort_reach", W'(hs_cnt), W'(8));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", W'(bus.busy), '0);
    chk("abort_st0", bus.st0_o, '0);
    chk("abort_st1", bus.st1_o, '0);
    chk("abort_ready", W'(bus.rnd_ready), '0);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    chk("abort_idle", W'(bus.busy), '0);

    r = {$urandom, $urandom, $urandom, $urandom};
    run_pass(r, r, {NB{8'h65}}, 0, 1'b0, 1'b0);

    r  = {$urandom, $urandom, $urandom, $urandom};
    s1 = {$urandom, $urandom, $urandom, $urandom};
    for (int b = 0; b < NB; b++) x[8*b +: 8] = s8(r[8*b +: 8] ^ s1[8*b +: 8]);
    run_pass(r, s1, x, 0, 1'b0, 1'b1);

    for (int n = 0; n < 64; n++) begin
      r  = {$urandom, $urandom, $urandom, $urandom};
      s1 = {$urandom, $urandom, $urandom, $urandom};
      for (int b = 0; b < NB; b++) x[8*b +: 8] = s8(r[8*b +: 8] ^ s1[8*b +: 8]);
      run_pass(r, s1, x, 0, 1'b0, 1'b0);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
